// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial input line plus the bus-side FIFO and status signals
// of the UART receive stage. The master is the bus or line side, and the
// slave is the receiver.
interface uart_rx_fifo_if #(
    parameter int BUFFER_SIZE = 16
);
    localparam int CountWidth = $clog2(BUFFER_SIZE) + 1;

    logic                  rx;
    logic                  rd_en;
    logic                  clr_err;
    logic [7:0]            rd_data;
    logic                  empty;
    logic                  full;
    logic [CountWidth-1:0] count;
    logic                  overrun;
    logic                  frame_err;
    logic                  parity_err;

    modport master (
        output rx, rd_en, clr_err,
        input  rd_data, empty, full, count, overrun, frame_err, parity_err
    );

    modport slave (
        input  rx, rd_en, clr_err,
        output rd_data, empty, full, count, overrun, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive stage. It deserialises 8N1 frames from an
// asynchronous rx line and buffers the bytes in a power-of-two FIFO. The FIFO
// head is presented first-word-fall-through, with pop-on-read, an occupancy
// count and sticky error flags.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames with an
// even-parity check. In the default build, parity_err is tied to 0.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ  = 25000000,
    parameter int BAUD_RATE   = 115200,
    parameter int BUFFER_SIZE = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int PTR_W        = $clog2(BUFFER_SIZE);
    localparam int COUNT_W      = PTR_W + 1;

    localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [COUNT_W-1:0] FULL_CNT  = COUNT_W'(BUFFER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic               r_rxMeta;
    logic               r_rxSync;
    logic               r_rxPrev;
    logic [1:0]         r_warmCnt;
    state_t             r_state;
    logic [CNT_W-1:0]   r_clkCnt;
    logic [2:0]         r_bitCnt;
    logic [7:0]         r_shift;
    logic               r_frameErr;
`ifdef UART_RX_PARITY_EN
    logic               r_parityErr;
    logic               r_parityBad;
`endif
    logic [7:0]         r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [COUNT_W-1:0] r_count;
    logic               r_overrun;

    logic w_fallEdge;
    logic w_stopSample;
    logic w_pushReq;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_overrunEvt;

    // Start edges are ignored until the line has been sampled for real after
    // reset. This stops a line held low through reset release from looking
    // like a start bit.
    assign w_fallEdge   = (r_warmCnt == 2'd3) && r_rxPrev && !r_rxSync;
    assign w_stopSample = (r_state == S_STOP) && (r_clkCnt == BIT_LAST);
`ifdef UART_RX_PARITY_EN
    assign w_pushReq    = w_stopSample && r_rxSync && !r_parityBad;
`else
    assign w_pushReq    = w_stopSample && r_rxSync;
`endif

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_pop        = bus.rd_en && !w_empty;
    assign w_push       = w_pushReq && (!w_full || w_pop);
    assign w_overrunEvt = w_pushReq && w_full && !w_pop;

    // Two-flop synchroniser for rx, the previous-sample flop used for edge
    // detection, and a short warm-up count after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxMeta  <= 1'b1;
            r_rxSync  <= 1'b1;
            r_rxPrev  <= 1'b1;
            r_warmCnt <= 2'd0;
        end else begin
            r_rxMeta <= bus.rx;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
            if (r_warmCnt != 2'd3) begin
                r_warmCnt <= r_warmCnt + 2'd1;
            end
        end
    end

    // Frame FSM: start-bit qualification, mid-bit data sampling, optional
    // parity and stop check. When a new error and clr_err land on the same
    // edge, the set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_clkCnt    <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_frameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parityErr <= 1'b0;
            r_parityBad <= 1'b0;
`endif
        end else begin
            if (bus.clr_err) begin
                r_frameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_parityErr <= 1'b0;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    r_clkCnt <= '0;
                    r_bitCnt <= '0;
                    if (w_fallEdge) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_clkCnt == HALF_LAST) begin
                        r_clkCnt <= '0;
                        r_state  <= r_rxSync ? S_IDLE : S_DATA;
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_clkCnt == BIT_LAST) begin
                        r_clkCnt <= '0;
                        r_shift  <= {r_rxSync, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_clkCnt == BIT_LAST) begin
                        r_clkCnt    <= '0;
                        r_parityBad <= ^{r_shift, r_rxSync};
                        if (^{r_shift, r_rxSync}) begin
                            r_parityErr <= 1'b1;
                        end
                        r_state <= S_STOP;
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (r_clkCnt == BIT_LAST) begin
                        r_clkCnt <= '0;
                        if (!r_rxSync) begin
                            r_frameErr <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage is not reset. Stale entries are never visible because
    // rd_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy and the sticky overrun flag. A push into a
    // full FIFO is accepted only when a pop frees a slot on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (bus.clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_overrunEvt) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.rd_data   = w_empty ? 8'h00 : r_mem[r_rdPtr];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frameErr;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_parityErr;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo in its default 8N1
// build. The expected state is a byte queue plus flag bits, updated from the
// frame-level rules of the receiver.
module tb_uart_rx_fifo;
    localparam int ClockFreq  = 2_050_000;
    localparam int BaudRate   = 100_000;
    localparam int ClksPerBit = ClockFreq / BaudRate;
    localparam int Depth      = 16;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         gap;
        int         expCount;
        logic [7:0] expHead;
        logic       expFrameErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_fifo_if #(.BUFFER_SIZE(Depth)) busIf ();

    uart_rx_fifo #(
        .CLOCK_FREQ (ClockFreq),
        .BAUD_RATE  (BaudRate),
        .BUFFER_SIZE(Depth)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (busIf)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] refQ[$];
    logic       refOverrun;
    logic       refFrameErr;
    int         lastLatency;
    int         pushLatency;
    vec_t       vecs[5];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        refQ.delete();
        refOverrun  = 1'b0;
        refFrameErr = 1'b0;
    endtask

    task automatic modelFrame(input logic [7:0] data, input logic stopBit);
        if (!stopBit) begin
            refFrameErr = 1'b1;
        end else if (refQ.size() == Depth) begin
            refOverrun = 1'b1;
        end else begin
            refQ.push_back(data);
        end
    endtask

    task automatic modelPop();
        if (refQ.size() > 0) begin
            void'(refQ.pop_front());
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".count"}, int'(busIf.count), refQ.size());
        check({tag, ".empty"}, int'(busIf.empty), int'(refQ.size() == 0));
        check({tag, ".full"}, int'(busIf.full), int'(refQ.size() == Depth));
        if (refQ.size() > 0) begin
            check({tag, ".rd_data"}, int'(busIf.rd_data), int'(refQ[0]));
        end
        check({tag, ".overrun"}, int'(busIf.overrun), int'(refOverrun));
        check({tag, ".frame_err"}, int'(busIf.frame_err), int'(refFrameErr));
        check({tag, ".parity_err"}, int'(busIf.parity_err), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame, optionally pulsing rd_en or clr_err so that it is
    // sampled on edge popAt or clrAt (counted from the start-bit drive). The
    // task also records the edge at which empty first dropped.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int popAt, input int clrAt);
        logic [9:0] frame;
        int         edgeN;
        logic       wasEmpty;
        int         seen;
        frame    = {stopBit, data, 1'b0};
        edgeN    = 0;
        wasEmpty = busIf.empty;
        seen     = -1;
        for (int b = 0; b < 10; b++) begin
            busIf.rx = frame[b];
            for (int c = 0; c < ClksPerBit; c++) begin
                if (edgeN == popAt - 1) busIf.rd_en = 1'b1;
                if (edgeN == clrAt - 1) busIf.clr_err = 1'b1;
                @(posedge clk);
                #1;
                edgeN++;
                busIf.rd_en   = 1'b0;
                busIf.clr_err = 1'b0;
                if (wasEmpty && seen < 0 && !busIf.empty) seen = edgeN;
            end
        end
        busIf.rx    = 1'b1;
        lastLatency = seen;
    endtask

    task automatic popOnce();
        busIf.rd_en = 1'b1;
        @(posedge clk);
        #1;
        busIf.rd_en = 1'b0;
        modelPop();
    endtask

    task automatic clrPulse();
        busIf.clr_err = 1'b1;
        @(posedge clk);
        #1;
        busIf.clr_err = 1'b0;
        refOverrun  = 1'b0;
        refFrameErr = 1'b0;
    endtask

    // Upper bound on run time so that a stuck design still reaches the summary.
    initial begin
        #5_000_000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [7:0] rd;
        logic       rs;
        int         lo;
        int         hi;

        vecs[0] = '{8'h00, 1'b1, 0, 1, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 0, 2, 8'h00, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 0, 3, 8'h00, 1'b0};
        vecs[3] = '{8'h77, 1'b0, 4, 3, 8'h00, 1'b1};
        vecs[4] = '{8'h81, 1'b1, 0, 4, 8'h00, 1'b1};

        busIf.rx      = 1'b1;
        busIf.rd_en   = 1'b0;
        busIf.clr_err = 1'b0;
        rst_n         = 1'b0;
        modelReset();
        idle(3);
        checkOutput("reset");
        check("reset.rd_data", int'(busIf.rd_data), 0);
        rst_n = 1'b1;
        idle(5);
        popOnce();
        checkOutput("emptyPop");

        // The first frame arrives about 9.5 bit times after the start edge.
        applyStimulus(8'hA5, 1'b1, 0, 0);
        modelFrame(8'hA5, 1'b1);
        pushLatency = lastLatency;
        lo = 9 * ClksPerBit + ClksPerBit / 2;
        hi = lo + 5;
        checks++;
        if (pushLatency < lo || pushLatency > hi) begin
            errors++;
            $display("[TB] FAIL latency actual=%0d expected=%0d..%0d", pushLatency, lo, hi);
        end
        checkOutput("frameA5");
        popOnce();
        checkOutput("readA5");

        // Table-driven frames, back-to-back, with one bad stop bit.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stopBit, 0, 0);
            modelFrame(vecs[i].data, vecs[i].stopBit);
            check($sformatf("vec%0d.count", i), int'(busIf.count), vecs[i].expCount);
            check($sformatf("vec%0d.head", i), int'(busIf.rd_data), int'(vecs[i].expHead));
            check($sformatf("vec%0d.ferr", i), int'(busIf.frame_err), int'(vecs[i].expFrameErr));
            checkOutput($sformatf("vec%0d", i));
            idle(vecs[i].gap);
        end
        for (int i = 0; i < 4; i++) begin
            popOnce();
            checkOutput($sformatf("vecRead%0d", i));
        end
        clrPulse();
        checkOutput("vecClr");

        // Overflow: 17 bytes with no reads. The 17th byte is dropped.
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(8'(i), 1'b1, 0, 0);
            modelFrame(8'(i), 1'b1);
        end
        check("ovf.full", int'(busIf.full), 1);
        check("ovf.count", int'(busIf.count), 16);
        check("ovf.overrun", int'(busIf.overrun), 1);
        checkOutput("ovf");
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("ovfRead%0d", i), int'(busIf.rd_data), i);
            popOnce();
        end
        checkOutput("ovfDrained");
        clrPulse();
        checkOutput("ovfClr");

        // With the FIFO full, pop on exactly the edge where the next byte is
        // pushed.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(8'h20 + i), 1'b1, 0, 0);
            modelFrame(8'(8'h20 + i), 1'b1);
        end
        checkOutput("refill");
        applyStimulus(8'hEE, 1'b1, pushLatency, 0);
        modelPop();
        modelFrame(8'hEE, 1'b1);
        check("pushPop.count", int'(busIf.count), 16);
        check("pushPop.overrun", int'(busIf.overrun), 0);
        checkOutput("pushPop");
        for (int i = 0; i < 16; i++) begin
            popOnce();
            checkOutput($sformatf("pushPopRead%0d", i));
        end

        // A short glitch is rejected, and a low stop bit sets frame_err.
        busIf.rx = 1'b0;
        idle(3);
        busIf.rx = 1'b1;
        idle(2 * ClksPerBit);
        checkOutput("glitch");
        applyStimulus(8'h5C, 1'b0, 0, 0);
        modelFrame(8'h5C, 1'b0);
        idle(4);
        checkOutput("badStop");
        clrPulse();
        checkOutput("badStopClr");
        // When clr_err arrives on the same edge as a new frame error, the set
        // wins.
        applyStimulus(8'h33, 1'b0, 0, pushLatency);
        modelFrame(8'h33, 1'b0);
        idle(4);
        checkOutput("setWins");
        clrPulse();
        checkOutput("setWinsClr");

        // Reset mid-frame with data and flags pending. The line is then held
        // low through reset release.
        for (int i = 0; i < 6; i++) begin
            rs = (i != 2);
            applyStimulus(8'(8'h10 + i), rs, 0, 0);
            modelFrame(8'(8'h10 + i), rs);
            idle(rs ? 0 : 4);
        end
        checkOutput("preReset");
        busIf.rx = 1'b0;
        idle(3 * ClksPerBit);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        idle(3);
        rst_n = 1'b1;
        idle(12 * ClksPerBit);
        checkOutput("lowAfterReset");
        busIf.rx = 1'b1;
        idle(5);
        applyStimulus(8'h5A, 1'b1, 0, 0);
        modelFrame(8'h5A, 1'b1);
        checkOutput("after5A");
        popOnce();
        checkOutput("read5A");

        // Random frames, reads and clears checked against the byte-queue model.
        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(9) != 0);
            applyStimulus(rd, rs, 0, 0);
            modelFrame(rd, rs);
            checkOutput($sformatf("rnd%0d", i));
            idle(rs ? int'($urandom_range(0, 3)) : int'($urandom_range(3, 6)));
            if ($urandom_range(1) == 1) begin
                popOnce();
                checkOutput($sformatf("rndPop%0d", i));
            end
            if ($urandom_range(7) == 0) begin
                clrPulse();
                checkOutput($sformatf("rndClr%0d", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
